adder_sched: RTL and testbench
==============================

# adder_sched

Round-robin scheduler that shares one pipelined 2-input adder (`adder` with `num=2`) among NUM independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, drives the adder's `valid`/`i0`/`i1`, and tracks request tags through the adder pipeline. It routes each `o`/`valid_out` result back to the originating requester. It sits between client logic and a single adder instance, replacing per-client adders.

## Interface
- BITS, 16, operand/result width; must match the shared adder
- NUM, 4, number of requesters, 2..16
- LATENCY, 1, adder cycles from `valid` to `valid_out`, ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM  per-requester operand pair valid
- req_ready  out  NUM  per-requester grant, one-hot or zero
- req_a  in  NUM*BITS  operand a; requester k at bits [k*BITS +: BITS]
- req_b  in  NUM*BITS  operand b, same packing
- add_valid  out  1  to adder `valid`
- add_i0  out  BITS  to adder `i0`
- add_i1  out  BITS  to adder `i1`
- add_o  in  BITS  from adder `o`
- add_valid_out  in  1  from adder `valid_out`
- rsp_valid  out  NUM  one-hot result strobe
- rsp_data  out  BITS  result, shared by all requesters
- busy  out  1  any operation in flight
- err  out  1  sticky: `add_valid_out` arrived with no matching tag, or the expected result did not arrive

## Operation
- Arbitration is round-robin, combinational from `req_valid` and the priority pointer.
- The search starts at requester `ptr`. After a grant to k, `ptr` becomes (k+1) mod NUM.
- `ptr` does not move in a cycle with no grant.
- `req_ready[k]` is high only for the granted k. It never depends on anything except `req_valid` and state.
- A transfer occurs on a rising edge where `req_valid[k] & req_ready[k]`.
- Transfer registers:
  - `add_valid` is set to 1.
  - `add_i0` takes `req_a[k]`; `add_i1` takes `req_b[k]`.
  - The tag k enters a LATENCY-stage tag shift register together with a valid bit.
- With no transfer, `add_valid` is 0 and the operands hold their last value.
- Result return, when the tag pipe's last stage aligns with `add_valid_out`:
  - Registers `rsp_valid` = onehot(tag) and `rsp_data` = `add_o`.
  - Otherwise `rsp_valid` is 0 and `rsp_data` holds.
- There is no response backpressure. Requesters must accept `rsp_valid` the cycle it is asserted.
- Arithmetic: the sum is modulo 2^BITS, as produced by the adder; the block never alters data.
- Error check: the last tag-stage valid must equal `add_valid_out` every cycle. On a mismatch, `err` is set to 1 and stays 1 until reset. The response is suppressed that cycle.
- Outstanding counter (width clog2(LATENCY+3)):
  - Increments on a transfer and decrements on an `rsp_valid` cycle.
  - Both in the same cycle leave it unchanged.
  - `busy` = (counter ≠ 0).
- Requesters may issue back-to-back. Full throughput is one operation per cycle with no bubbles.

## Timing
- Reset values:
  - `ptr` = 0; the tag pipe is all invalid; the counter is 0.
  - Outputs: `add_valid` 0, `add_i0`/`add_i1` 0, `rsp_valid` 0, `rsp_data` 0, `busy` 0, `err` 0.
  - `req_ready` is 0 while `reset` is high.
- Transfer at edge t gives `add_valid` high in cycle t+1. The adder returns `add_valid_out` at t+1+LATENCY. `rsp_valid` is high at t+2+LATENCY, which is cycle t+3 for LATENCY=1.
- Reset asserted mid-operation drops all in-flight tags; no response is emitted for them.
  - The surrounding adder is reset by the same `reset` signal, so results cannot leak out.
  - If a stale `add_valid_out` does arrive, `err` is set.
- Simultaneous requests from all NUM requesters: each is served exactly once in every NUM consecutive grant cycles.

## Structure
- Package `adder_sched_pkg` holds:
  - TAG_W = max(1, clog2(NUM));
  - the tag type (valid bit + TAG_W tag);
  - the onehot helper.
- Sub-module `rr_arbiter` (parameter NUM) provides the request vector → one-hot grant plus pointer update. It is reused by other shared-resource schedulers.
- The tag shift register, response register, and counter live in `adder_sched`.

## Test plan
- Single request: req 2 sends a=3, b=4 at edge t → `rsp_valid` = 4'b0100 with `rsp_data` = 7 at t+3 (LATENCY=1); `busy` high from t+1 through t+3.
- All four requesters valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3; one `add_valid` every cycle; each result returns to the correct requester; `err` stays 0.
- Pointer fairness: req 1 and req 3 valid, last grant was 1 → next grant is 3, then 1.
- Wrap-around: a=16'hFFFF, b=16'h0002 → `rsp_data` = 16'h0001.
- Reset asserted 1 cycle after two transfers → no `rsp_valid` afterwards; `busy` = 0 and `err` = 0 after reset.
- Injected spurious `add_valid_out` with an empty tag pipe → `err` goes to 1 the next cycle and stays until reset; no `rsp_valid`.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the adder scheduler: request tag carried
// alongside each operation through the shared adder pipeline.
package adder_sched_pkg;

    localparam int MAX_NUM = 16;
    localparam int TAG_W   = (MAX_NUM > 2) ? $clog2(MAX_NUM) : 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_t;

    function automatic logic [MAX_NUM-1:0] onehot(input logic [TAG_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, searching from a
// priority pointer that moves past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int NUM = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NUM-1:0] req,
    output logic [NUM-1:0] grant
);

    localparam int PTR_W = (NUM > 2) ? $clog2(NUM) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [NUM-1:0]   mask;
    logic [NUM-1:0]   masked;
    logic [NUM-1:0]   pick;

    // Requests at or above ptr win first; otherwise wrap to the lowest request.
    always_comb begin
        mask   = ~((NUM'(1) << ptr) - NUM'(1));
        masked = req & mask;
        pick   = (|masked) ? masked : req;
        grant  = pick & (~pick + NUM'(1));
    end

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        ptr_next = ptr;
        for (int k = 0; k < NUM; k++) begin
            if (grant[k]) begin
                ptr_next = (k == NUM - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/adder_sched.sv
// Shares one pipelined adder among NUM requesters: round-robin issue, tag
// tracking through the adder latency, and result routing back to the owner.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int NUM     = 4,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM-1:0]    req_valid,
    output logic [NUM-1:0]    req_ready,
    input  logic [NUM*BITS-1:0] req_a,
    input  logic [NUM*BITS-1:0] req_b,
    output logic              add_valid,
    output logic [BITS-1:0]   add_i0,
    output logic [BITS-1:0]   add_i1,
    input  logic [BITS-1:0]   add_o,
    input  logic              add_valid_out,
    output logic [NUM-1:0]    rsp_valid,
    output logic [BITS-1:0]   rsp_data,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(LATENCY + 3);

    logic [NUM-1:0]   grant;
    logic             xfer;
    logic [TAG_W-1:0] sel_tag;
    logic [BITS-1:0]  a_sel;
    logic [BITS-1:0]  b_sel;
    tag_t             issue_tag;
    tag_t             tag_pipe [LATENCY];
    tag_t             last;
    logic [CNT_W-1:0] cnt;

    rr_arbiter #(.NUM(NUM)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = reset ? '0 : grant;
    assign xfer      = |(req_valid & req_ready);
    assign add_valid = issue_tag.valid;
    assign last      = tag_pipe[LATENCY-1];
    assign busy      = (cnt != '0);

    always_comb begin
        sel_tag = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int k = 0; k < NUM; k++) begin
            if (grant[k]) begin
                sel_tag = TAG_W'(k);
                a_sel   = req_a[k*BITS +: BITS];
                b_sel   = req_b[k*BITS +: BITS];
            end
        end
    end

    // issue_tag lines up with add_valid; tag_pipe then follows the adder's latency.
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_tag <= '0;
            add_i0    <= '0;
            add_i1    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            issue_tag <= '{valid: xfer, tag: sel_tag};
            if (xfer) begin
                add_i0 <= a_sel;
                add_i1 <= b_sel;
            end

            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            rsp_valid <= '0;
            if (last.valid && add_valid_out) begin
                rsp_valid <= NUM'(onehot(last.tag));
                rsp_data  <= add_o;
            end
            if (last.valid != add_valid_out) begin
                err <= 1'b1;
            end

            case ({xfer, |rsp_valid})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched with a behavioural 1-cycle adder and a
// spurious-result injection hook.
module tb_adder_sched;

    localparam int BITS    = 16;
    localparam int NUM     = 4;
    localparam int LATENCY = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM-1:0]    req_valid;
    logic [NUM-1:0]    req_ready;
    logic [NUM*BITS-1:0] req_a;
    logic [NUM*BITS-1:0] req_b;
    logic              add_valid;
    logic [BITS-1:0]   add_i0;
    logic [BITS-1:0]   add_i1;
    logic [BITS-1:0]   add_o;
    logic              add_valid_out;
    logic [NUM-1:0]    rsp_valid;
    logic [BITS-1:0]   rsp_data;
    logic              busy;
    logic              err;

    logic              adder_vo;
    logic              inject;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_sched #(.BITS(BITS), .NUM(NUM), .LATENCY(LATENCY)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .add_valid     (add_valid),
        .add_i0        (add_i0),
        .add_i1        (add_i1),
        .add_o         (add_o),
        .add_valid_out (add_valid_out),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .err           (err)
    );

    // Shared adder stand-in, reset by the same signal as the scheduler.
    always_ff @(posedge clk) begin
        if (reset) begin
            adder_vo <= 1'b0;
            add_o    <= '0;
        end else begin
            adder_vo <= add_valid;
            add_o    <= add_i0 + add_i1;
        end
    end

    assign add_valid_out = adder_vo | inject;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        req_a[k*BITS +: BITS] = a;
        req_b[k*BITS +: BITS] = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        inject    = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", req_ready, 4'b0000);
        check("rst_add_valid", add_valid, 0);
        check("rst_add_i0", add_i0, 0);
        check("rst_add_i1", add_i1, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        req_valid = '0;
        reset     = 1'b0;

        // Single request from requester 2: 3 + 4
        set_req(2, 16'd3, 16'd4);
        req_valid = 4'b0100;
        #1;
        check("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("single_add_valid", add_valid, 1);
        check("single_add_i0", add_i0, 3);
        check("single_add_i1", add_i1, 4);
        check("single_busy_t1", busy, 1);
        check("single_rsp_t1", rsp_valid, 0);
        tick();
        check("single_add_valid_t2", add_valid, 0);
        check("single_add_i0_hold", add_i0, 3);
        check("single_busy_t2", busy, 1);
        check("single_rsp_t2", rsp_valid, 0);
        tick();
        check("single_rsp_valid", rsp_valid, 4'b0100);
        check("single_rsp_data", rsp_data, 7);
        check("single_busy_t3", busy, 1);
        tick();
        check("single_rsp_clear", rsp_valid, 0);
        check("single_rsp_hold", rsp_data, 7);
        check("single_busy_done", busy, 0);

        // All four continuously valid for 8 cycles from a fresh pointer
        do_reset();
        for (int s = 0; s < 10; s++) begin
            if (s < 8) begin
                for (int k = 0; k < NUM; k++) begin
                    set_req(k, BITS'(k * 256 + s), 16'h0010);
                end
                req_valid = 4'b1111;
                #1;
                check($sformatf("rr_ready_%0d", s), req_ready, 32'(1) << (s % 4));
            end else begin
                req_valid = '0;
            end
            tick();
            if (s < 8) check($sformatf("rr_add_valid_%0d", s), add_valid, 1);
            if (s >= 2) begin
                check($sformatf("rr_rsp_valid_%0d", s - 2), rsp_valid, 32'(1) << ((s - 2) % 4));
                check($sformatf("rr_rsp_data_%0d", s - 2), rsp_data,
                      32'(((s - 2) % 4) * 256 + (s - 2) + 16));
            end
        end
        check("rr_err", err, 0);

        // Fairness: last grant was 1, requests from 1 and 3
        do_reset();
        req_valid = 4'b0010;
        #1;
        check("fair_first", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1010;
        #1;
        check("fair_next3", req_ready, 4'b1000);
        tick();
        #1;
        check("fair_then1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("fair_err", err, 0);

        // Modulo wrap-around on requester 0
        set_req(0, 16'hFFFF, 16'h0002);
        req_valid = 4'b0001;
        #1;
        check("wrap_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (2) tick();
        check("wrap_rsp_valid", rsp_valid, 4'b0001);
        check("wrap_rsp_data", rsp_data, 16'h0001);
        tick();

        // Reset one cycle after two transfers drops them
        req_valid = 4'b0011;
        #1;
        check("rstmid_ready1", req_ready, 4'b0010);
        tick();
        #1;
        check("rstmid_ready0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("rstmid_ready_in_reset", req_ready, 4'b0000);
        repeat (2) tick();
        reset     = 1'b0;
        req_valid = '0;
        check("rstmid_busy", busy, 0);
        check("rstmid_err", err, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rstmid_no_rsp_%0d", i), rsp_valid, 0);
        end
        check("rstmid_err_after", err, 0);

        // Spurious add_valid_out with an empty tag pipe
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("spur_err", err, 1);
        check("spur_no_rsp", rsp_valid, 0);
        repeat (3) tick();
        check("spur_err_sticky", err, 1);
        check("spur_no_rsp_later", rsp_valid, 0);
        do_reset();
        check("spur_err_cleared", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
